// File: rtl/mod_counter_p.sv
// mod_counter_p: parametrised modulo / saturating up-down counter with
// prescaler, synchronous clear and parallel load, a registered
// terminal-count pulse (tc) and a sticky boundary-event flag (ovf).
//
// Optional feature, enabled by defining MOD_COUNTER_P_CAPTURE_EN:
//   adds cap_stb / cap_val, a snapshot register that latches the count
//   value present before the edge on which cap_stb is high.
//
// Parameters:
//   WIDTH    counter width in bits (1..32)
//   MODULUS  count range 0..MODULUS-1; 0 selects the full 2^WIDTH range
//   PRESCALE enabled cycles per count step (1..65535)
//   SATURATE 0 = wrap at the bounds, 1 = hold at the bounds
module mod_counter_p #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MODULUS  = 0,
  parameter int unsigned     PRESCALE = 1,
  parameter int unsigned     SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef MOD_COUNTER_P_CAPTURE_EN
  input  logic             cap_stb,
  output logic [WIDTH-1:0] cap_val,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  // Upper bound of the count range. MODULUS may equal 2^WIDTH, so it is
  // carried as a 64-bit parameter and reduced to WIDTH bits only after the
  // subtraction.
  localparam logic [WIDTH-1:0] MAX_VAL =
    (MODULUS != 0) ? WIDTH'(MODULUS - 1) : {WIDTH{1'b1}};

  // Prescaler width; a PRESCALE of 1 still gets a 1-bit register that
  // simply never leaves zero.
  localparam int unsigned PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;

  localparam bit SAT_MODE = (SATURATE != 0);

  // One action per edge, in priority order (rst is handled in the
  // register process itself).
  typedef enum logic [2:0] {
    ACT_HOLD,    // en low: everything holds
    ACT_CLEAR,   // synchronous restart
    ACT_LOAD,    // parallel load, clamped to MAX_VAL
    ACT_TICK,    // enabled cycle that only advances the prescaler
    ACT_STEP     // enabled cycle that moves the count
  } act_e;

  // Registered state
  logic [WIDTH-1:0] count_q, count_d;
  logic [PS_W-1:0]  ps_q,    ps_d;
  logic             tc_q,    tc_d;
  logic             ovf_q,   ovf_d;

  // Decode helpers
  act_e             act;
  logic             step_due;
  logic             at_max;
  logic             at_zero;
  logic             bound_hit;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;

  // Decode which single action applies on this edge.
  always_comb begin
    // NOTE: every variable written in an always_comb gets a default first so
    // no path leaves it unassigned; that is what keeps latches from being
    // inferred.
    act      = ACT_HOLD;
    step_due = en && (ps_q == PS_LAST);

    if (clear) begin
      act = ACT_CLEAR;
    end else if (load) begin
      act = ACT_LOAD;
    end else if (en) begin
      act = step_due ? ACT_STEP : ACT_TICK;
    end
  end

  // Boundary detection and the candidate next-count values. The bounds are
  // compared explicitly, so a non-power-of-two modulus never depends on the
  // natural WIDTH-bit rollover.
  always_comb begin
    at_max       = (count_q == MAX_VAL);
    at_zero      = (count_q == CNT_ZERO);
    bound_hit    = up ? at_max : at_zero;
    load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    count_inc    = count_q + CNT_ONE;
    count_dec    = count_q - CNT_ONE;
  end

  // Next-state logic for count, prescaler, tc and ovf.
  always_comb begin
    count_d = count_q;
    ps_d    = ps_q;
    tc_d    = 1'b0;   // tc is a single-cycle pulse unless an event re-arms it
    ovf_d   = ovf_q;

    unique case (act)
      ACT_CLEAR: begin
        count_d = CNT_ZERO;
        ps_d    = '0;
        ovf_d   = 1'b0;
      end

      ACT_LOAD: begin
        // ovf is sticky across a load; only clear or rst drop it.
        count_d = load_clamped;
        ps_d    = '0;
      end

      ACT_TICK: begin
        ps_d = ps_q + PS_ONE;
      end

      ACT_STEP: begin
        ps_d = '0;
        if (bound_hit) begin
          // Wrap or saturate event: both raise tc and ovf. In saturate mode
          // every blocked step is its own event.
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          if (SAT_MODE) begin
            count_d = count_q;
          end else begin
            count_d = up ? CNT_ZERO : MAX_VAL;
          end
        end else begin
          count_d = up ? count_inc : count_dec;
        end
      end

      default: begin
        // ACT_HOLD: prescaler and count hold while en is low.
      end
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement
    // order.
    if (rst) begin
      count_q <= CNT_ZERO;
      ps_q    <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ps_q    <= ps_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

`ifdef MOD_COUNTER_P_CAPTURE_EN
  logic [WIDTH-1:0] cap_val_q, cap_val_d;

  // Snapshot the pre-update count on a strobe; clear and load leave it alone.
  always_comb begin
    cap_val_d = cap_stb ? count_q : cap_val_q;
  end

  // Capture register, reset only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_val_q <= CNT_ZERO;
    end else begin
      cap_val_q <= cap_val_d;
    end
  end

  assign cap_val = cap_val_q;
`endif

endmodule

// File: tb/tb_mod_counter_p.sv
// Bench for mod_counter_p. Three instances cover the wrap, saturate and
// prescale configurations; a table of vectors, hand-written corner
// sequences and a random phase against a small reference model all feed
// expected values through a scoreboard queue.
module tb_mod_counter_p;

  typedef struct packed {
    logic       en;
    logic       up;
    logic       clear;
    logic       load;
    logic [7:0] load_val;
  } in_t;

  typedef struct {
    in_t in;
    int  cnt;
    bit  tc;
    bit  ovf;
  } vec_t;

  typedef struct {
    int    which;
    string tag;
    int    cnt;
    bit    tc;
    bit    ovf;
  } exp_t;

  typedef struct {
    int cnt;
    int ps;
    bit tc;
    bit ovf;
  } mdl_t;

  logic clk;
  logic rst;
  in_t  in_a, in_b, in_c;

  logic [7:0] count_a, count_c;
  logic [3:0] count_b;
  logic       tc_a, tc_b, tc_c;
  logic       ovf_a, ovf_b, ovf_c;

`ifdef MOD_COUNTER_P_CAPTURE_EN
  logic       cap_stb_a;
  logic [7:0] cap_val_a;
`endif

  int n_cmp;
  int n_err;
  exp_t sb[$];

  // A: 8-bit, modulo 10, wrap, every enabled cycle steps
  mod_counter_p #(.WIDTH(8), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_a (
    .clk      (clk),
    .rst      (rst),
    .en       (in_a.en),
    .up       (in_a.up),
    .clear    (in_a.clear),
    .load     (in_a.load),
    .load_val (in_a.load_val),
`ifdef MOD_COUNTER_P_CAPTURE_EN
    .cap_stb  (cap_stb_a),
    .cap_val  (cap_val_a),
`endif
    .count    (count_a),
    .tc       (tc_a),
    .ovf      (ovf_a)
  );

  // B: 4-bit, full range, saturating
  mod_counter_p #(.WIDTH(4), .MODULUS(0), .PRESCALE(1), .SATURATE(1)) u_b (
    .clk      (clk),
    .rst      (rst),
    .en       (in_b.en),
    .up       (in_b.up),
    .clear    (in_b.clear),
    .load     (in_b.load),
    .load_val (4'(in_b.load_val)),
    .count    (count_b),
    .tc       (tc_b),
    .ovf      (ovf_b)
  );

  // C: 8-bit, modulo 10, wrap, one step per 4 enabled cycles
  mod_counter_p #(.WIDTH(8), .MODULUS(10), .PRESCALE(4), .SATURATE(0)) u_c (
    .clk      (clk),
    .rst      (rst),
    .en       (in_c.en),
    .up       (in_c.up),
    .clear    (in_c.clear),
    .load     (in_c.load),
    .load_val (in_c.load_val),
    .count    (count_c),
    .tc       (tc_c),
    .ovf      (ovf_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int which, input string tag, input int cnt, input bit tc, input bit ovf);
    exp_t e;
    e.which = which;
    e.tag   = tag;
    e.cnt   = cnt;
    e.tc    = tc;
    e.ovf   = ovf;
    sb.push_back(e);
  endtask

  // Advance one clock, then drain the scoreboard against the settled outputs.
  task automatic cycle();
    exp_t        e;
    logic [31:0] act_cnt;
    logic        act_tc;
    logic        act_ovf;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.which)
        0:       begin act_cnt = 32'(count_a); act_tc = tc_a; act_ovf = ovf_a; end
        1:       begin act_cnt = 32'(count_b); act_tc = tc_b; act_ovf = ovf_b; end
        default: begin act_cnt = 32'(count_c); act_tc = tc_c; act_ovf = ovf_c; end
      endcase
      check({e.tag, "_count"}, act_cnt, e.cnt);
      check({e.tag, "_tc"}, 32'(act_tc), 32'(e.tc));
      check({e.tag, "_ovf"}, 32'(act_ovf), 32'(e.ovf));
    end
  endtask

  function automatic vec_t mk(input bit en, input bit up, input bit clr, input bit ld,
                              input int lv, input int cnt, input bit tc, input bit ovf);
    vec_t v;
    v.in.en       = en;
    v.in.up       = up;
    v.in.clear    = clr;
    v.in.load     = ld;
    v.in.load_val = 8'(lv);
    v.cnt         = cnt;
    v.tc          = tc;
    v.ovf         = ovf;
    return v;
  endfunction

  // Reference behaviour: integer arithmetic, explicit bounds.
  function automatic mdl_t model_step(input mdl_t m, input in_t i, input int lv,
                                      input int maxv, input int pre, input bit sat);
    mdl_t n;
    n    = m;
    n.tc = 1'b0;
    if (i.clear) begin
      n.cnt = 0; n.ps = 0; n.ovf = 1'b0;
    end else if (i.load) begin
      n.cnt = (lv > maxv) ? maxv : lv;
      n.ps  = 0;
    end else if (i.en) begin
      if (m.ps + 1 < pre) begin
        n.ps = m.ps + 1;
      end else begin
        n.ps = 0;
        if (i.up && m.cnt == maxv) begin
          n.tc = 1'b1; n.ovf = 1'b1; n.cnt = sat ? maxv : 0;
        end else if (!i.up && m.cnt == 0) begin
          n.tc = 1'b1; n.ovf = 1'b1; n.cnt = sat ? 0 : maxv;
        end else begin
          n.cnt = i.up ? m.cnt + 1 : m.cnt - 1;
        end
      end
    end
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    mdl_t ma, mb, mc;
    int   e_cnt;

    n_cmp = 0;
    n_err = 0;
    in_a  = '0;
    in_b  = '0;
    in_c  = '0;
`ifdef MOD_COUNTER_P_CAPTURE_EN
    cap_stb_a = 1'b0;
`endif

    // Vectors for instance A, applied after reset.
    for (int k = 1; k <= 9; k++) vecs.push_back(mk(1, 1, 0, 0, 0, k, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,   0, 1, 1));  // 9 -> 0 wrap
    vecs.push_back(mk(1, 1, 0, 0, 0,   1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0,   1, 0, 1));  // stable while en=0
    vecs.push_back(mk(1, 1, 1, 0, 0,   0, 0, 0));  // clear beats en
    vecs.push_back(mk(1, 0, 0, 0, 0,   9, 1, 1));  // 0 -> 9 down wrap
    vecs.push_back(mk(1, 0, 0, 0, 0,   8, 0, 1));
    vecs.push_back(mk(1, 1, 0, 1, 12,  9, 0, 1));  // clamped load, no step
    vecs.push_back(mk(1, 1, 0, 0, 0,   0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 1, 5,   5, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1, 7,   0, 0, 0));  // clear beats load
    vecs.push_back(mk(0, 1, 0, 1, 9,   9, 0, 0));  // load keeps ovf
    vecs.push_back(mk(1, 0, 0, 0, 0,   8, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,   9, 0, 0));  // direction change
    vecs.push_back(mk(0, 1, 0, 1, 10,  9, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,   0, 1, 1));
    vecs.push_back(mk(1, 1, 0, 1, 3,   3, 0, 1));  // load drops tc
    vecs.push_back(mk(0, 1, 0, 1, 255, 9, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0,   9, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0,   0, 1, 1));

    // Reset state of all instances.
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    push(0, "rst_a", 0, 0, 0);
    push(1, "rst_b", 0, 0, 0);
    push(2, "rst_c", 0, 0, 0);
    cycle();
`ifdef MOD_COUNTER_P_CAPTURE_EN
    check("rst_cap_val", 32'(cap_val_a), 0);
`endif

    foreach (vecs[i]) begin
      in_a = vecs[i].in;
      push(0, $sformatf("a_vec%0d", i), vecs[i].cnt, vecs[i].tc, vecs[i].ovf);
      cycle();
    end
    in_a = '0;

    // Saturating instance: load 14, then four up steps against the top.
    in_b = '{en: 1'b0, up: 1'b1, clear: 1'b0, load: 1'b1, load_val: 8'd14};
    push(1, "b_load", 14, 0, 0);
    cycle();
    in_b = '{en: 1'b1, up: 1'b1, clear: 1'b0, load: 1'b0, load_val: 8'd0};
    push(1, "b_sat1", 15, 0, 0); cycle();
    push(1, "b_sat2", 15, 1, 1); cycle();
    push(1, "b_sat3", 15, 1, 1); cycle();
    push(1, "b_sat4", 15, 1, 1); cycle();
    in_b.en = 1'b0;
    push(1, "b_idle", 15, 0, 1); cycle();
    in_b.clear = 1'b1;
    push(1, "b_clear", 0, 0, 0); cycle();
    in_b = '{en: 1'b1, up: 1'b0, clear: 1'b0, load: 1'b0, load_val: 8'd0};
    push(1, "b_sat_dn", 0, 1, 1); cycle();
    in_b.up = 1'b1;
    push(1, "b_up", 1, 0, 1); cycle();
    in_b = '0;

    // Prescale-by-4: 22 enabled cycles with a 3-cycle gap after the 10th.
    e_cnt = 0;
    in_c.up = 1'b1;
    for (int k = 0; k < 25; k++) begin
      in_c.en = !(k >= 10 && k < 13);
      if (in_c.en) e_cnt++;
      push(2, $sformatf("c_ps%0d", k), e_cnt / 4, 0, 0);
      cycle();
    end
    // rst lands mid-prescale (two enabled cycles into a step).
    rst = 1'b1;
    push(0, "rst2_a", 0, 0, 0);
    push(1, "rst2_b", 0, 0, 0);
    push(2, "rst2_c", 0, 0, 0);
    cycle();
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      push(2, $sformatf("c_after_rst%0d", k), (k == 4) ? 1 : 0, 0, 0);
      cycle();
    end
    in_c = '0;

    // Random phase on all three instances, starting from a common reset.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    ma = '{0, 0, 1'b0, 1'b0};
    mb = ma;
    mc = ma;
    for (int k = 0; k < 300; k++) begin
      in_a = '{en: ($urandom_range(0, 3) != 0), up: ($urandom_range(0, 1) != 0),
               clear: ($urandom_range(0, 39) == 0), load: ($urandom_range(0, 15) == 0),
               load_val: 8'($urandom_range(0, 255))};
      in_b = '{en: ($urandom_range(0, 3) != 0), up: ($urandom_range(0, 1) != 0),
               clear: ($urandom_range(0, 39) == 0), load: ($urandom_range(0, 15) == 0),
               load_val: 8'($urandom_range(0, 255))};
      in_c = '{en: ($urandom_range(0, 3) != 0), up: ($urandom_range(0, 1) != 0),
               clear: ($urandom_range(0, 39) == 0), load: ($urandom_range(0, 15) == 0),
               load_val: 8'($urandom_range(0, 255))};
      ma = model_step(ma, in_a, int'(in_a.load_val), 9, 1, 1'b0);
      mb = model_step(mb, in_b, int'(in_b.load_val) % 16, 15, 1, 1'b1);
      mc = model_step(mc, in_c, int'(in_c.load_val), 9, 4, 1'b0);
      push(0, "rnd_a", ma.cnt, ma.tc, ma.ovf);
      push(1, "rnd_b", mb.cnt, mb.tc, mb.ovf);
      push(2, "rnd_c", mc.cnt, mc.tc, mc.ovf);
      cycle();
    end
    in_a = '0;
    in_b = '0;
    in_c = '0;

`ifdef MOD_COUNTER_P_CAPTURE_EN
    // Capture while stepping: snapshot is the pre-edge count.
    in_a.clear = 1'b1;
    push(0, "cap_clr", 0, 0, 0); cycle();
    in_a = '{en: 1'b0, up: 1'b1, clear: 1'b0, load: 1'b1, load_val: 8'd6};
    push(0, "cap_ld", 6, 0, 0); cycle();
    in_a = '{en: 1'b1, up: 1'b1, clear: 1'b0, load: 1'b0, load_val: 8'd0};
    push(0, "cap_s7", 7, 0, 0); cycle();
    cap_stb_a = 1'b1;
    push(0, "cap_s8", 8, 0, 0); cycle();
    check("cap_val_7", 32'(cap_val_a), 7);
    cap_stb_a = 1'b0;
    push(0, "cap_s9", 9, 0, 0); cycle();
    check("cap_val_hold", 32'(cap_val_a), 7);
    in_a = '{en: 1'b0, up: 1'b1, clear: 1'b1, load: 1'b0, load_val: 8'd0};
    push(0, "cap_clr2", 0, 0, 0); cycle();
    check("cap_val_after_clear", 32'(cap_val_a), 7);
    in_a = '{en: 1'b0, up: 1'b1, clear: 1'b0, load: 1'b1, load_val: 8'd3};
    cap_stb_a = 1'b1;
    push(0, "cap_ld3", 3, 0, 0); cycle();
    check("cap_val_on_load", 32'(cap_val_a), 0);
    cap_stb_a = 1'b0;
    in_a = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
